vip_uart_agent: RTL

- Synthesizable, parametrised UART agent: TX and RX with FIFOs, runtime baud divisor, optional parity and 1/2 stop bits, sticky error flags.
- Generation-two bench UART. Replaces the fixed-baud, TX-char-only bus model in the VIP top. Also used on FPGA as the host-side loopback and pattern endpoint for the DUT UART.
- Sits between the bench sequencer, which drives the valid/ready streams, and the DUT `uart_rx`/`uart_tx` pins.

---
 rtl/vip_uart_agent.sv | 318 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vip_uart_agent.sv
// Bench/FPGA UART agent: TX and RX serialisers behind FIFOs, runtime bit divisor,
// optional parity, 1 or 2 stop bits and sticky receive error flags.

module vip_uart_fifo #(
   parameter int Width = 8,
   parameter int Depth = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             not_empty_o,
   output logic             not_full_o
);
   localparam int AW = $clog2(Depth);
   localparam logic [AW:0] FullCount = (AW+1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             not_empty_q, not_full_q;
   logic             do_push, do_pop;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_pop  = pop_i & not_empty_q;
   assign do_push = push_i & (not_full_q | do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         not_empty_q <= 1'b0;
         not_full_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q     <= count_d;
         not_empty_q <= (count_d != '0);
         not_full_q  <= (count_d != FullCount);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o      = mem_q[rd_ptr_q];
   assign not_empty_o = not_empty_q;
   assign not_full_o  = not_full_q;
endmodule

module vip_uart_agent #(
   parameter int DataBits    = 8,
   parameter int ClkDivW     = 16,
   parameter int TxFifoDepth = 8,
   parameter int RxFifoDepth = 8,
   parameter int ParityEn    = 0,
   parameter int ParityOdd   = 0,
   parameter int StopBits    = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [ClkDivW-1:0]  clk_div_i,
   input  logic [DataBits-1:0] tx_data_i,
   input  logic                tx_valid_i,
   output logic                tx_ready_o,
   output logic [DataBits-1:0] rx_data_o,
   output logic                rx_valid_o,
   input  logic                rx_ready_i,
   output logic                uart_tx_o,
   input  logic                uart_rx_i,
   output logic                tx_busy_o,
   input  logic                err_clear_i,
   output logic                rx_parity_err_o,
   output logic                rx_frame_err_o,
   output logic                rx_overflow_o
);
   // Streams: a word moves when valid and ready are both high at a rising edge;
   // tx_ready_o / rx_valid_o are registered FIFO flags, independent of same-cycle inputs.
   localparam int BW = $clog2(DataBits);
   localparam logic [BW-1:0] LastBit = BW'(DataBits - 1);
   localparam logic OddPar   = (ParityOdd != 0);
   localparam logic ParOn    = (ParityEn != 0);
   localparam logic LastStop = (StopBits == 2);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_e;

   logic [ClkDivW-1:0] div_eff;
   assign div_eff = (clk_div_i == '0) ? ClkDivW'(1) : clk_div_i;

   tx_state_e          tx_state_q;
   logic [ClkDivW-1:0] tx_div_q, tx_cnt_q;
   logic [BW-1:0]      tx_bit_q;
   logic [DataBits-1:0] tx_shift_q, tx_head;
   logic               tx_par_q, tx_stop_q, tx_line_q;
   logic               tx_not_empty, tx_not_full, tx_push, tx_pop, tx_bit_done;

   assign tx_push     = tx_valid_i & tx_not_full;
   assign tx_bit_done = (tx_cnt_q >= tx_div_q);
   // Popping at the end of the last stop bit makes frames run back to back.
   assign tx_pop = tx_not_empty & ((tx_state_q == TX_IDLE) |
                   ((tx_state_q == TX_STOP) & tx_bit_done & (tx_stop_q == LastStop)));

   vip_uart_fifo #(.Width(DataBits), .Depth(TxFifoDepth)) u_tx_fifo (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(tx_push), .data_i(tx_data_i), .pop_i(tx_pop),
      .data_o(tx_head), .not_empty_o(tx_not_empty), .not_full_o(tx_not_full)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_state_q <= TX_IDLE;
         tx_line_q  <= 1'b1;
         tx_div_q   <= '0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_stop_q  <= 1'b0;
      end else if (tx_pop) begin
         tx_state_q <= TX_START;
         tx_line_q  <= 1'b0;
         tx_div_q   <= div_eff;
         tx_cnt_q   <= ClkDivW'(1);
         tx_shift_q <= tx_head;
         tx_par_q   <= (^tx_head) ^ OddPar;
      end else begin
         case (tx_state_q)
            TX_START: begin
               if (tx_bit_done) begin
                  tx_state_q <= TX_DATA;
                  tx_line_q  <= tx_shift_q[0];
                  tx_cnt_q   <= ClkDivW'(1);
                  tx_bit_q   <= '0;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_bit_done) begin
                  tx_cnt_q <= ClkDivW'(1);
                  if (tx_bit_q == LastBit) begin
                     tx_state_q <= ParOn ? TX_PARITY : TX_STOP;
                     tx_line_q  <= ParOn ? tx_par_q : 1'b1;
                     tx_stop_q  <= 1'b0;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 1'b1;
                     tx_line_q  <= tx_shift_q[1];
                     tx_shift_q <= tx_shift_q >> 1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TX_PARITY: begin
               if (tx_bit_done) begin
                  tx_state_q <= TX_STOP;
                  tx_line_q  <= 1'b1;
                  tx_cnt_q   <= ClkDivW'(1);
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_bit_done) begin
                  if (tx_stop_q == LastStop) begin
                     tx_state_q <= TX_IDLE;
                  end else begin
                     tx_stop_q <= 1'b1;
                     tx_cnt_q  <= ClkDivW'(1);
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            default: tx_line_q <= 1'b1;
         endcase
      end
   end

   rx_state_e          rx_state_q;
   logic               rx_s1_q, rx_s2_q, rx_prev_q;
   logic [ClkDivW-1:0] rx_div_q, rx_cnt_q;
   logic [BW-1:0]      rx_bit_q;
   logic [DataBits-1:0] rx_shift_q;
   logic               rx_par_bit_q, rx_push_q, rx_par_evt_q, rx_frm_evt_q;
   logic               rx_fall, rx_bit_done, rx_half_done, rx_par_ok;
   logic               rx_not_empty, rx_not_full, rx_ovf_evt;
   logic               par_err_q, frm_err_q, ovf_q;

   assign rx_fall      = rx_prev_q & ~rx_s2_q;
   assign rx_bit_done  = (rx_cnt_q >= rx_div_q);
   assign rx_half_done = (rx_cnt_q >= (rx_div_q >> 1));
   assign rx_par_ok    = (((^rx_shift_q) ^ OddPar) == rx_par_bit_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_state_q   <= RX_IDLE;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_div_q     <= '0;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_par_bit_q <= 1'b0;
         rx_push_q    <= 1'b0;
         rx_par_evt_q <= 1'b0;
         rx_frm_evt_q <= 1'b0;
      end else begin
         rx_s1_q      <= uart_rx_i;
         rx_s2_q      <= rx_s1_q;
         rx_prev_q    <= rx_s2_q;
         rx_push_q    <= 1'b0;
         rx_par_evt_q <= 1'b0;
         rx_frm_evt_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_fall) begin
                  rx_state_q <= RX_START;
                  rx_div_q   <= div_eff;
                  rx_cnt_q   <= ClkDivW'(1);
               end
            end
            RX_START: begin
               // A start bit that is high again at mid-bit was a glitch.
               if (rx_half_done) begin
                  rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                  rx_cnt_q   <= ClkDivW'(1);
                  rx_bit_q   <= '0;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_bit_done) begin
                  rx_cnt_q   <= ClkDivW'(1);
                  rx_shift_q <= {rx_s2_q, rx_shift_q[DataBits-1:1]};
                  if (rx_bit_q == LastBit) begin
                     rx_state_q <= ParOn ? RX_PARITY : RX_STOP;
                  end else begin
                     rx_bit_q <= rx_bit_q + 1'b1;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_PARITY: begin
               if (rx_bit_done) begin
                  rx_par_bit_q <= rx_s2_q;
                  rx_state_q   <= RX_STOP;
                  rx_cnt_q     <= ClkDivW'(1);
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_bit_done) begin
                  if (!rx_s2_q) begin
                     rx_frm_evt_q <= 1'b1;
                     rx_state_q   <= RX_WAIT_IDLE;
                  end else begin
                     rx_state_q <= RX_IDLE;
                     if (ParOn && !rx_par_ok) rx_par_evt_q <= 1'b1;
                     else                     rx_push_q    <= 1'b1;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_WAIT_IDLE: begin
               if (rx_s2_q) rx_state_q <= RX_IDLE;
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   vip_uart_fifo #(.Width(DataBits), .Depth(RxFifoDepth)) u_rx_fifo (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_push_q), .data_i(rx_shift_q), .pop_i(rx_ready_i),
      .data_o(rx_data_o), .not_empty_o(rx_not_empty), .not_full_o(rx_not_full)
   );

   assign rx_ovf_evt = rx_push_q & ~rx_not_full & ~(rx_ready_i & rx_not_empty);

   // Set wins over err_clear_i when both land in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         par_err_q <= (par_err_q & ~err_clear_i) | rx_par_evt_q;
         frm_err_q <= (frm_err_q & ~err_clear_i) | rx_frm_evt_q;
         ovf_q     <= (ovf_q & ~err_clear_i) | rx_ovf_evt;
      end
   end

   assign tx_ready_o      = tx_not_full;
   assign rx_valid_o      = rx_not_empty;
   assign uart_tx_o       = tx_line_q;
   assign tx_busy_o       = tx_not_empty | (tx_state_q != TX_IDLE);
   assign rx_parity_err_o = par_err_q;
   assign rx_frame_err_o  = frm_err_q;
   assign rx_overflow_o   = ovf_q;
endmodule
